// File: rtl/vending_pkg.sv
// vending_pkg: coin codes shared by coin_acceptor and vending_machine
package vending_pkg;
    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_5    = 2'b01,
        COIN_10   = 2'b10
    } coin_e;
    function automatic coin_e coin_of(input logic is_five);
        return is_five ? COIN_5 : COIN_10;
    endfunction
endpackage

// File: rtl/coin_debouncer.sv
// coin_debouncer: 2-flop synchroniser, debounce counter and registered rising-edge strobe
module coin_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic rise_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0]    sync_q;
    logic          deb_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q;
    logic          differ;
    logic          flip;
    assign differ = sync_q[1] != deb_q;
    assign flip   = differ && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    assign rise_o = rise_q;
    // Reset to "occupied" so a sensor held high through reset never looks like a new coin
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
            deb_q  <= 1'b1;
            cnt_q  <= '0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            cnt_q  <= (!differ || flip) ? '0 : cnt_q + CW'(1);
            deb_q  <= flip ? sync_q[1] : deb_q;
            rise_q <= flip && sync_q[1];
        end
    end
endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces both coin sensors, queues coin events and replays them
// as single-cycle codes with a minimum idle gap between deliveries.
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int GAP_CYCLES      = 1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               coin5_raw,
    input  logic                               coin10_raw,
    output logic [1:0]                         coin_code,
    output logic                               reject,
    output logic                               overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 2);
    logic          rise5, rise10;
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q, count;
    logic [GW-1:0] gap_q;
    logic [1:0]    code_q;
    logic          reject_q, overflow_q;
    logic          full, pop, push_req, push;
    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clock  (clock),
        .reset  (reset),
        .raw_i  (coin5_raw),
        .rise_o (rise5)
    );
    coin_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clock  (clock),
        .reset  (reset),
        .raw_i  (coin10_raw),
        .rise_o (rise10)
    );
    assign count      = wr_ptr_q - rd_ptr_q;
    assign full       = count == (AW+1)'(FIFO_DEPTH);
    assign pop        = count != '0 && gap_q == '0;
    assign push_req   = rise5 ^ rise10;
    // A pop on the same edge frees a slot, so a full FIFO can still accept
    assign push       = push_req && (!full || pop);
    assign fifo_count = count;
    assign coin_code  = code_q;
    assign reject     = reject_q;
    assign overflow   = overflow_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= COIN_NONE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            gap_q      <= '0;
            code_q     <= COIN_NONE;
            reject_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= coin_of(rise5);
                wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            code_q     <= pop ? mem_q[rd_ptr_q[AW-1:0]] : COIN_NONE;
            gap_q      <= pop ? GW'(GAP_CYCLES) : gap_q - GW'(gap_q != '0);
            reject_q   <= rise5 && rise10;
            overflow_q <= push_req && !push;
        end
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: default DUT plus a fast-debounce/long-gap DUT, both checked every
// cycle against a queue-level behavioural model, with literal checks of key scenarios.
module tb_coin_acceptor;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic rst, raw5, raw10;
    logic [1:0] code0, code1;
    logic rej0o, rej1o, ovf0o, ovf1o;
    logic [2:0] fc0, fc1;
    int n_chk = 0, n_fail = 0, cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    coin_acceptor dut0 (
        .clock(clk), .reset(rst), .coin5_raw(raw5), .coin10_raw(raw10),
        .coin_code(code0), .reject(rej0o), .overflow(ovf0o), .fifo_count(fc0)
    );
    coin_acceptor #(.DEBOUNCE_CYCLES(1), .GAP_CYCLES(8)) dut1 (
        .clock(clk), .reset(rst), .coin5_raw(raw5), .coin10_raw(raw10),
        .coin_code(code1), .reject(rej1o), .overflow(ovf1o), .fifo_count(fc1)
    );
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Model: raw history -> synced history; debounced level flips once the last
    // DEB synced samples all disagree with it; coins kept in a plain shift list.
    logic [1:0] rawh [2];
    logic [7:0] hist [2];
    logic       mdeb [2][2];
    logic       mrise [2][2];
    int         mq [2][DEPTH];
    int         mc [2], mgap [2], mcode [2];
    int         mrej [2], movf [2];
    always @(posedge clk or posedge rst) begin
        logic e5, e10, p;
        logic [7:0] m;
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                rawh[c] = 2'b11;
                hist[c] = 8'hFF;
            end
            for (int i = 0; i < 2; i++) begin
                for (int c = 0; c < 2; c++) begin
                    mdeb[i][c] = 1'b1;
                    mrise[i][c] = 1'b0;
                end
                for (int j = 0; j < DEPTH; j++) mq[i][j] = 0;
                mc[i] = 0; mgap[i] = 0; mcode[i] = 0; mrej[i] = 0; movf[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                e5 = mrise[i][0];
                e10 = mrise[i][1];
                p = mc[i] > 0 && mgap[i] == 0;
                mcode[i] = p ? mq[i][0] : 0;
                if (p) begin
                    for (int j = 0; j < DEPTH - 1; j++) mq[i][j] = mq[i][j+1];
                    mc[i]--;
                end
                mgap[i] = p ? (i == 0 ? 1 : 8) : (mgap[i] > 0 ? mgap[i] - 1 : 0);
                mrej[i] = (e5 && e10) ? 1 : 0;
                movf[i] = 0;
                if (e5 != e10) begin
                    if (mc[i] < DEPTH) begin
                        mq[i][mc[i]] = e5 ? 1 : 2;
                        mc[i]++;
                    end else movf[i] = 1;
                end
            end
            for (int c = 0; c < 2; c++) begin
                hist[c] = {hist[c][6:0], rawh[c][1]};
                rawh[c] = {rawh[c][0], (c == 0) ? raw5 : raw10};
            end
            for (int i = 0; i < 2; i++) begin
                m = (i == 0) ? 8'h0F : 8'h01;
                for (int c = 0; c < 2; c++) begin
                    mrise[i][c] = 1'b0;
                    if ((hist[c] & m) == (mdeb[i][c] ? 8'h00 : m)) begin
                        mdeb[i][c] = ~mdeb[i][c];
                        mrise[i][c] = mdeb[i][c];
                    end
                end
            end
        end
    end
    int codes0[$], times0[$], codes1[$];
    int rejc0 = 0, rejc1 = 0, ovfc0 = 0, ovfc1 = 0, peak1 = 0, maxfc0 = 0;
    always @(negedge clk) begin
        chk("code0", code0, mcode[0]);
        chk("count0", fc0, mc[0]);
        chk("reject0", rej0o, mrej[0]);
        chk("overflow0", ovf0o, movf[0]);
        chk("code1", code1, mcode[1]);
        chk("count1", fc1, mc[1]);
        chk("reject1", rej1o, mrej[1]);
        chk("overflow1", ovf1o, movf[1]);
        if (code0 != 2'b00) begin
            codes0.push_back(code0);
            times0.push_back(cyc);
        end
        if (code1 != 2'b00) codes1.push_back(code1);
        rejc0 += rej0o; rejc1 += rej1o; ovfc0 += ovf0o; ovfc1 += ovf1o;
        if (fc1 > peak1) peak1 = fc1;
        if (fc0 > maxfc0) maxfc0 = fc0;
    end
    initial begin
        int s0, s1, r0, o0, k, found;
        int bounce[5];
        bounce = '{1, 0, 1, 1, 0};
        rst = 1'b1; raw5 = 1'b1; raw10 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s0 = codes0.size(); s1 = codes1.size(); r0 = rejc0 + rejc1; o0 = ovfc0 + ovfc1;
        repeat (50) @(negedge clk);
        chk("t1_quiet_codes", codes0.size() - s0 + codes1.size() - s1, 0);
        chk("t1_quiet_flags", rejc0 + rejc1 + ovfc0 + ovfc1 - r0 - o0, 0);
        chk("t1_reset_count", fc0, 0);
        raw5 = 1'b0;
        repeat (6) @(negedge clk);
        s0 = codes0.size();
        raw5 = 1'b1; k = cyc + 1;
        repeat (8) @(negedge clk);
        raw5 = 1'b0;
        repeat (12) @(negedge clk);
        chk("t1_one_coin", codes0.size() - s0, 1);
        if (codes0.size() > s0) begin
            chk("t1_code", codes0[s0], 1);
            chk("t1_latency", times0[s0] - k, 7);
        end
        s0 = codes0.size();
        for (int j = 0; j < 5; j++) begin
            raw10 = bounce[j][0];
            @(negedge clk);
        end
        raw10 = 1'b1;
        repeat (10) @(negedge clk);
        raw10 = 1'b0;
        repeat (14) @(negedge clk);
        chk("t2_bounce_one", codes0.size() - s0, 1);
        if (codes0.size() > s0) chk("t2_code", codes0[s0], 2);
        s0 = codes0.size();
        raw10 = 1'b1;
        repeat (3) @(negedge clk);
        raw10 = 1'b0;
        repeat (14) @(negedge clk);
        chk("t2_glitch", codes0.size() - s0, 0);
        s0 = codes0.size(); r0 = rejc0; maxfc0 = 0;
        raw5 = 1'b1; raw10 = 1'b1;
        repeat (8) @(negedge clk);
        raw5 = 1'b0; raw10 = 1'b0;
        repeat (14) @(negedge clk);
        chk("t3_reject", rejc0 - r0, 1);
        chk("t3_no_code", codes0.size() - s0, 0);
        chk("t3_no_queue", maxfc0, 0);
        s0 = codes0.size();
        raw5 = 1'b1;
        repeat (2) @(negedge clk);
        raw10 = 1'b1;
        repeat (4) @(negedge clk);
        raw5 = 1'b0;
        repeat (2) @(negedge clk);
        raw10 = 1'b0;
        repeat (8) @(negedge clk);
        raw5 = 1'b1;
        repeat (6) @(negedge clk);
        raw5 = 1'b0;
        repeat (14) @(negedge clk);
        chk("t4_count", codes0.size() - s0, 3);
        if (codes0.size() - s0 == 3) begin
            chk("t4_first", codes0[s0], 1);
            chk("t4_second", codes0[s0+1], 2);
            chk("t4_third", codes0[s0+2], 1);
            chk("t4_gap", times0[s0+1] - times0[s0], 2);
        end
        repeat (50) @(negedge clk);
        s1 = codes1.size(); o0 = ovfc1; peak1 = 0;
        for (int j = 0; j < 6; j++) begin
            raw5 = (j % 2 == 0); raw10 = (j % 2 == 1);
            @(negedge clk);
        end
        raw5 = 1'b0; raw10 = 1'b0;
        repeat (70) @(negedge clk);
        chk("t5_peak", peak1, 4);
        chk("t5_overflow", ovfc1 - o0, 1);
        chk("t5_delivered", codes1.size() - s1, 5);
        if (codes1.size() - s1 == 5)
            for (int j = 0; j < 5; j++) chk("t5_order", codes1[s1+j], (j % 2 == 0) ? 1 : 2);
        for (int j = 0; j < 4; j++) begin
            raw5 = (j % 2 == 0); raw10 = (j % 2 == 1);
            @(negedge clk);
        end
        raw5 = 1'b0; raw10 = 1'b0;
        found = 0;
        for (int j = 0; j < 20 && found == 0; j++) begin
            @(negedge clk);
            if (fc1 == 3'd3) found = 1;
        end
        chk("t6_reached_three", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_count1", fc1, 0);
        chk("t6_async_code1", code1, 0);
        chk("t6_async_count0", fc0, 0);
        chk("t6_async_code0", code0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s0 = codes0.size(); s1 = codes1.size();
        repeat (30) @(negedge clk);
        chk("t6_no_codes", codes0.size() - s0 + codes1.size() - s1, 0);
        for (int j = 0; j < 1500; j++) begin
            if ($urandom_range(0, 5) == 0) raw5 = ~raw5;
            if ($urandom_range(0, 5) == 0) raw10 = ~raw10;
            @(negedge clk);
        end
        for (int j = 0; j < 300; j++) begin
            if ($urandom_range(0, 1) == 0) raw5 = ~raw5;
            if ($urandom_range(0, 1) == 0) raw10 = ~raw10;
            @(negedge clk);
        end
        raw5 = 1'b0; raw10 = 1'b0;
        repeat (60) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
